// File: rtl/serial_sub8_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master = producer/consumer side, slave = the subtractor.
interface serial_sub8_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
endinterface

// File: rtl/serial_sub8.sv
// Bit-serial subtractor: (a - b - bin) computed LSB first through one
// full-subtractor cell, one bit per RUN cycle, valid/ready on both sides.
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub8_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, part, diff_q;
  logic             br, bout_q;
  logic [CW-1:0]    cnt;
  logic             d, br_nxt, last;

  // single full-subtractor cell
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_nxt = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
  assign last   = (cnt == LAST);

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      part   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sa  <= bus.a;
          sb  <= bus.b;
          br  <= bus.bin;
          cnt <= '0;
        end
        RUN: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          part <= {d, part[WIDTH-1:1]};
          br   <= br_nxt;
          // result registers change only on the completing edge
          if (last) begin
            diff_q <= {d, part[WIDTH-1:1]};
            bout_q <= br_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: doc/serial_sub8.md
SERIAL_SUB8 -- requirements
Module: serial_sub8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operands a, b, bin are presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  minuend, unsigned.
REQ-007 SHALL have port b  input  WIDTH  subtrahend, unsigned.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  diff and bout hold a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
REQ-012 SHALL have port bout  output  1  borrow-out, 1 iff a < b + bin (unsigned).

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE, both decoded from state.
REQ-015 SHALL accept operands on a rising edge where in_valid=1 and in_ready=1: capture a, b into shift registers, load borrow flop with bin, clear bit counter, go to RUN.
REQ-016 SHALL ignore in_valid and operand changes while in RUN or DONE.
REQ-017 SHALL process exactly one bit per RUN cycle, LSB first, using a single full-subtractor cell.
REQ-018 SHALL compute each bit as d = a_i ^ b_i ^ br and br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br).
REQ-019 SHALL shift d into an internal partial-result register and br_next into the borrow flop each RUN cycle.
REQ-020 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1, which is the WIDTH-th edge after the accept edge.
REQ-021 SHALL load diff and bout from the partial register and borrow flop on that same edge.
REQ-022 SHALL hold diff and bout stable from that edge until the next completion, including through DONE and IDLE.
REQ-023 SHALL stay in DONE, with diff, bout and out_valid stable, for as long as out_ready=0.
REQ-024 SHALL go from DONE to IDLE on a rising edge where out_ready=1.
REQ-025 SHALL provide no same-cycle bypass: in_ready rises the cycle after the result transfer, so back-to-back operations take WIDTH+2 cycles each.
REQ-026 SHALL size the bit counter to ceil(log2(WIDTH)) bits, with no wrap-around beyond WIDTH-1.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state=IDLE, diff=0, bout=0, borrow flop=0, counter=0 and shift registers=0.
REQ-028 SHALL therefore show in_ready=1 and out_valid=0 while rst_n=0, and SHALL accept no operands until the first rising edge with rst_n=1.
REQ-029 SHALL abandon any in-flight RUN or DONE operation on reset with no result emitted, and the next operation after reset SHALL be correct.

Verification
REQ-030 SHALL pass: a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0; out_valid rises exactly 8 edges after accept.
REQ-031 SHALL pass: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0.
REQ-032 SHALL pass: a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
REQ-033 SHALL pass: out_ready held 0 for 5 cycles in DONE, with new in_valid operands driven during RUN and DONE -> diff, bout, out_valid unchanged, new operands not captured, in_ready=0 throughout.
REQ-034 SHALL pass: rst_n pulsed low after the 4th RUN edge -> immediately out_valid=0, in_ready=1, diff=0; next op 0x10-0x01 -> diff=0x0F, bout=0.
REQ-035 SHALL pass: 256 random back-to-back ops with out_ready=1 -> one accept every 10 cycles, every result matching a reference model.
